// File: rtl/interruptus_pkg.sv
// Shared definitions for interruptus_irq: register map, CTRL bit positions,
// FSM state encoding and the RETI opcode pair.
package interruptus_pkg;

  localparam logic [7:0] ADDR_RELOAD_LO = 8'h1D;
  localparam logic [7:0] ADDR_RELOAD_HI = 8'h1E;
  localparam logic [7:0] ADDR_CTRL      = 8'h1F;
  localparam logic [7:0] ADDR_VECTOR    = 8'h20;

  // CTRL write bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_W1C    = 1;
  localparam int CTRL_EOI    = 2;

  // CTRL read bits (ENABLE shares bit 0)
  localparam int STAT_PENDING = 1;
  localparam int STAT_INSVC   = 2;
  localparam int STAT_OVERRUN = 3;

  localparam logic [7:0] OPC_RETI_PREFIX = 8'hED;
  localparam logic [7:0] OPC_RETI        = 8'h4D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ACK   = 2'd2,
    ST_INSVC = 2'd3
  } irq_state_e;

  function automatic logic [7:0] ctrl_status(input logic enable, input logic pending,
                                             input logic insvc, input logic overrun);
    logic [7:0] s;
    s = '0;
    s[CTRL_ENABLE]  = enable;
    s[STAT_PENDING] = pending;
    s[STAT_INSVC]   = insvc;
    s[STAT_OVERRUN] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/irq_bus_sync.sv
// Two-flop synchronizer for one active-low Z80 strobe, plus a third flop for
// edge detection. Resets to the inactive (high) level.
module irq_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall,
  output logic rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;
  assign rise     = ~prev_q & sync_q;

endmodule

// File: rtl/interruptus_irq.sv
// Periodic interrupt source on a Z80 bus: reload down-counter, PENDING/OVERRUN
// status, vectored IM2 acknowledge. Optional RETI snooping: IRQ_RETI_DETECT_EN.
module interruptus_irq
  import interruptus_pkg::*;
(
  input  logic        gclk1,
  input  logic        resetn,
  input  logic [19:0] A,
  inout  wire  [7:0]  d,
  input  logic        iorqn,
  input  logic        m1n,
  input  logic        rdn,
  input  logic        wrn,
  input  logic        tick,
  output logic        intn,
  output logic        irq_active,
  output irq_state_e  dbg_state
);

  // Bus protocol: strobes are active-low and asynchronous. IO cycle = iorqn low
  // with m1n high; ACK cycle = iorqn and m1n both low. A write commits once on the
  // synchronized falling edge of wrn inside an IO cycle; A and d must be stable
  // from before wrn falls until it rises. Reads and the vector are driven
  // combinationally from the raw strobes.
  logic iorq_s, m1_s, wr_fall, m1_rise;
  logic unused_iorq_f, unused_iorq_r, unused_m1_f;
  logic unused_rd_s, unused_rd_f, unused_rd_r, unused_wr_s, unused_wr_r;
  logic unused_addr_hi;

  irq_bus_sync u_sync_iorq (.clk(gclk1), .rst_n(resetn), .async_in(iorqn),
                            .sync_out(iorq_s), .fall(unused_iorq_f), .rise(unused_iorq_r));
  irq_bus_sync u_sync_m1   (.clk(gclk1), .rst_n(resetn), .async_in(m1n),
                            .sync_out(m1_s), .fall(unused_m1_f), .rise(m1_rise));
  irq_bus_sync u_sync_rd   (.clk(gclk1), .rst_n(resetn), .async_in(rdn),
                            .sync_out(unused_rd_s), .fall(unused_rd_f), .rise(unused_rd_r));
  irq_bus_sync u_sync_wr   (.clk(gclk1), .rst_n(resetn), .async_in(wrn),
                            .sync_out(unused_wr_s), .fall(wr_fall), .rise(unused_wr_r));

  assign unused_addr_hi = ^A[19:8];

  irq_state_e  state_q, state_d;
  logic [7:0]  reload_lo_q, reload_lo_d, reload_hi_q, reload_hi_d;
  logic [6:0]  vector_q, vector_d;
  logic        enable_q, enable_d, pending_q, pending_d, overrun_q, overrun_d;
  logic [15:0] cnt_q, cnt_d;
  logic        intn_q, intn_d, irq_active_q, irq_active_d;

  logic        io_cycle_s, ack_cycle_s, wr_commit, w1c, eoi, reti;
  logic        event_fire, take_ack;
  logic [7:0]  rd_data;
  logic        rd_hit, drive_io, drive_vec;

  assign io_cycle_s  = ~iorq_s & m1_s;
  assign ack_cycle_s = ~iorq_s & ~m1_s;
  assign wr_commit   = wr_fall & io_cycle_s;
  assign w1c         = wr_commit & (A[7:0] == ADDR_CTRL) & d[CTRL_W1C];
  assign eoi         = wr_commit & (A[7:0] == ADDR_CTRL) & d[CTRL_EOI];
  assign event_fire  = tick & enable_q & (cnt_q == 16'd0);
  assign take_ack    = (state_q == ST_PEND) & enable_q & ack_cycle_s;

`ifdef IRQ_RETI_DETECT_EN
  // A fetch is an M1 cycle that ends with iorqn high; ED followed directly by 4D is RETI.
  logic ed_seen_q, ed_seen_d, fetch_end;

  assign fetch_end = m1_rise & iorq_s;

  always_comb begin
    ed_seen_d = ed_seen_q;
    reti      = 1'b0;
    if (fetch_end) begin
      reti      = ed_seen_q & (d == OPC_RETI);
      ed_seen_d = (d == OPC_RETI_PREFIX);
    end
  end

  always_ff @(posedge gclk1 or negedge resetn) begin
    if (!resetn) ed_seen_q <= 1'b0;
    else         ed_seen_q <= ed_seen_d;
  end
`else
  logic unused_m1_rise;
  assign unused_m1_rise = m1_rise;
  assign reti           = 1'b0;
`endif

  always_comb begin
    reload_lo_d = reload_lo_q;
    reload_hi_d = reload_hi_q;
    enable_d    = enable_q;
    vector_d    = vector_q;
    if (wr_commit) begin
      case (A[7:0])
        ADDR_RELOAD_LO: reload_lo_d = d;
        ADDR_RELOAD_HI: reload_hi_d = d;
        ADDR_CTRL:      enable_d    = d[CTRL_ENABLE];
        ADDR_VECTOR:    vector_d    = d[7:1];
        default:        ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tick && enable_q) begin
      cnt_d = (cnt_q == 16'd0) ? {reload_hi_q, reload_lo_q} : cnt_q - 16'd1;
    end
    if (wr_commit && (A[7:0] == ADDR_RELOAD_HI)) cnt_d = {d, reload_lo_q};
  end

  // Order matters: acknowledge clears, a new event sets, W1C has the last word.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (take_ack) pending_d = 1'b0;
    if (event_fire) begin
      if (pending_q) overrun_d = 1'b1;
      pending_d = 1'b1;
    end
    if (w1c) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pending_q && enable_q) state_d = ST_PEND;
      ST_PEND: begin
        if (!enable_q)        state_d = ST_IDLE;
        else if (ack_cycle_s) state_d = ST_ACK;
      end
      ST_ACK:   if (!ack_cycle_s) state_d = ST_INSVC;
      ST_INSVC: if (eoi || reti) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    intn_d       = ~((state_d == ST_PEND) || (state_d == ST_ACK));
    irq_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge gclk1 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      reload_lo_q  <= '0;
      reload_hi_q  <= '0;
      vector_q     <= '0;
      enable_q     <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= '0;
      intn_q       <= 1'b1;
      irq_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reload_lo_q  <= reload_lo_d;
      reload_hi_q  <= reload_hi_d;
      vector_q     <= vector_d;
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      intn_q       <= intn_d;
      irq_active_q <= irq_active_d;
    end
  end

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = '0;
    case (A[7:0])
      ADDR_RELOAD_LO: rd_data = reload_lo_q;
      ADDR_RELOAD_HI: rd_data = reload_hi_q;
      ADDR_CTRL:      rd_data = ctrl_status(enable_q, pending_q, state_q == ST_INSVC, overrun_q);
      ADDR_VECTOR:    rd_data = {vector_q, 1'b0};
      default:        rd_hit  = 1'b0;
    endcase
  end

  // Gated by resetn so the bus is released the moment reset asserts.
  assign drive_io  = resetn & ~iorqn & m1n & ~rdn & rd_hit;
  assign drive_vec = resetn & ~iorqn & ~m1n & ((state_q == ST_PEND) | (state_q == ST_ACK));
  assign d = drive_io ? rd_data : (drive_vec ? {vector_q, 1'b0} : 8'hzz);

  assign intn       = intn_q;
  assign irq_active = irq_active_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_interruptus_irq.sv
// Bench for interruptus_irq: directed bus scenarios plus randomized tick/reload
// rounds checked against a counting model. Define IRQ_RETI_DETECT_EN for the RETI build.
module tb_interruptus_irq;
  import interruptus_pkg::*;

  logic        gclk1 = 1'b0;
  logic        resetn = 1'b0;
  logic [19:0] A = '0;
  logic        iorqn = 1'b1, m1n = 1'b1, rdn = 1'b1, wrn = 1'b1, tick = 1'b0;
  logic        intn, irq_active;
  irq_state_e  dbg_state;
  wire  [7:0]  d;
  logic [7:0]  tb_d = '0;
  logic        tb_d_oe = 1'b0;

  assign d = tb_d_oe ? tb_d : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d[i]);
  end

  interruptus_irq dut (
    .gclk1(gclk1), .resetn(resetn), .A(A), .d(d), .iorqn(iorqn), .m1n(m1n),
    .rdn(rdn), .wrn(wrn), .tick(tick), .intn(intn), .irq_active(irq_active),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 gclk1 = ~gclk1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge gclk1);
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data,
                           input bit tick_on_commit = 1'b0);
    @(negedge gclk1);
    A = {12'($urandom), addr}; tb_d = data; tb_d_oe = 1'b1; iorqn = 1'b0;
    @(negedge gclk1); wrn = 1'b0;
    @(negedge gclk1);
    @(negedge gclk1); if (tick_on_commit) tick = 1'b1;
    @(negedge gclk1); tick = 1'b0;
    cyc(1); wrn = 1'b1; iorqn = 1'b1;
    cyc(1); tb_d_oe = 1'b0;
    cyc(3);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge gclk1);
    A = {12'($urandom), addr}; iorqn = 1'b0; rdn = 1'b0;
    @(posedge gclk1); #1 data = d;
    @(negedge gclk1); iorqn = 1'b1; rdn = 1'b1;
    cyc(3);
  endtask

  task automatic expect_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] got;
    exp_q.push_back(exp);
    bus_read(addr, got);
    check(tag, {8'h0, got}, {8'h0, exp_q.pop_front()});
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge gclk1); tick = 1'b1;
      @(negedge gclk1); tick = 1'b0;
    end
  endtask

  task automatic wait_intn(input string tag, input logic exp, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (intn === exp) break;
      @(negedge gclk1);
    end
    check(tag, {15'h0, intn}, {15'h0, exp});
  endtask

  task automatic ack_cycle(input logic [7:0] exp_vec, input bit reset_mid);
    @(negedge gclk1); iorqn = 1'b0; m1n = 1'b0;
    cyc(4);
    check("ack_vector", {8'h0, d}, {8'h0, exp_vec});
    check("intn_in_ack", {15'h0, intn}, 16'h0);
    if (reset_mid) begin
      resetn = 1'b0;
      #1;
      check("rst_intn", {15'h0, intn}, 16'h1);
      check("rst_irq_active", {15'h0, irq_active}, 16'h0);
      check("rst_d_released", {8'h0, d}, 16'h00FF);
      @(negedge gclk1); iorqn = 1'b1; m1n = 1'b1;
      cyc(2); resetn = 1'b1;
      cyc(3);
    end else begin
      @(negedge gclk1); iorqn = 1'b1; m1n = 1'b1;
      cyc(5);
    end
  endtask

  task automatic fetch(input logic [7:0] opc);
    @(negedge gclk1); tb_d = opc; tb_d_oe = 1'b1; m1n = 1'b0; rdn = 1'b0;
    cyc(3); m1n = 1'b1; rdn = 1'b1;
    cyc(4); tb_d_oe = 1'b0;
    cyc(1);
  endtask

  // ---------------- reference model for random rounds ----------------
  int         cnt_m;
  logic [15:0] reload_m;
  bit         pend_m, ovr_m, ever_m;

  function automatic logic [7:0] ctrl_model(input bit en, input bit pend, input bit insvc, input bit ovr);
    return {4'h0, ovr, insvc, pend, en};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] vec;
    int n;
    bit t;

    cyc(3);
    check("rst_intn0", {15'h0, intn}, 16'h1);
    check("rst_active0", {15'h0, irq_active}, 16'h0);
    check("rst_d0", {8'h0, d}, 16'h00FF);
    check("rst_state0", {14'h0, dbg_state}, {14'h0, ST_IDLE});
    resetn = 1'b1;
    cyc(3);
    expect_read("ctrl_after_reset", ADDR_CTRL, 8'h00);
    expect_read("unmapped_1c", 8'h1C, 8'hFF);
    expect_read("unmapped_21", 8'h21, 8'hFF);

    // Reload 3: events on the 4th tick
    bus_write(ADDR_VECTOR, 8'h41);
    bus_write(ADDR_RELOAD_LO, 8'h03);
    bus_write(ADDR_RELOAD_HI, 8'h00);
    bus_write(ADDR_CTRL, 8'h01);
    expect_read("vector_rb", ADDR_VECTOR, 8'h40);
    expect_read("reload_lo_rb", ADDR_RELOAD_LO, 8'h03);
    tick_n(3);
    cyc(4);
    check("intn_before_4th", {15'h0, intn}, 16'h1);
    tick_n(1);
    wait_intn("intn_after_4th", 1'b0, 6);
    check("active_pend", {15'h0, irq_active}, 16'h1);
    expect_read("ctrl_pend", ADDR_CTRL, 8'h03);

    // Acknowledge, then two more events while in service
    ack_cycle(8'h40, 1'b0);
    expect_read("ctrl_insvc", ADDR_CTRL, 8'h05);
    check("intn_insvc", {15'h0, intn}, 16'h1);
    tick_n(4);
    expect_read("ctrl_insvc_pend", ADDR_CTRL, 8'h07);
    tick_n(4);
    expect_read("ctrl_insvc_ovr", ADDR_CTRL, 8'h0F);
    check("intn_insvc2", {15'h0, intn}, 16'h1);
    bus_write(ADDR_CTRL, 8'h05);
    wait_intn("intn_after_eoi", 1'b0, 6);
    expect_read("ctrl_after_eoi", ADDR_CTRL, 8'h0B);

    // Disable while requesting, then re-enable
    bus_write(ADDR_CTRL, 8'h00);
    wait_intn("intn_disabled", 1'b1, 6);
    expect_read("ctrl_disabled", ADDR_CTRL, 8'h0A);
    bus_write(ADDR_CTRL, 8'h01);
    wait_intn("intn_reenabled", 1'b0, 6);

    // W1C coincident with an event (reload 0 -> every tick is an event)
    bus_write(ADDR_RELOAD_LO, 8'h00);
    bus_write(ADDR_RELOAD_HI, 8'h00);
    bus_write(ADDR_CTRL, 8'h03, 1'b1);
    expect_read("ctrl_w1c_wins", ADDR_CTRL, 8'h01);

    // Reset in the middle of an acknowledge
    ack_cycle(8'h40, 1'b1);
    expect_read("ctrl_after_ack_reset", ADDR_CTRL, 8'h00);
    check("intn_after_ack_reset", {15'h0, intn}, 16'h1);

    // RETI snooping (or its absence)
    vec = 8'($urandom);
    bus_write(ADDR_VECTOR, vec);
    bus_write(ADDR_CTRL, 8'h01);
    tick_n(1);
    wait_intn("intn_reti_setup", 1'b0, 6);
    ack_cycle(vec & 8'hFE, 1'b0);
    expect_read("ctrl_reti_insvc", ADDR_CTRL, 8'h05);
    fetch(8'hED);
    fetch(8'h4D);
`ifdef IRQ_RETI_DETECT_EN
    expect_read("ctrl_reti_exit", ADDR_CTRL, 8'h01);
`else
    expect_read("ctrl_no_reti", ADDR_CTRL, 8'h05);
    bus_write(ADDR_CTRL, 8'h05);
    expect_read("ctrl_eoi_exit", ADDR_CTRL, 8'h01);
`endif
    tick_n(1);
    wait_intn("intn_reti_setup2", 1'b0, 6);
    ack_cycle(vec & 8'hFE, 1'b0);
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    expect_read("ctrl_broken_reti", ADDR_CTRL, 8'h05);
    bus_write(ADDR_CTRL, 8'h05);
    expect_read("ctrl_eoi_final", ADDR_CTRL, 8'h01);

    // Randomized rounds against the counting model
    resetn = 1'b0; cyc(2); resetn = 1'b1; cyc(3);
    cnt_m = 0; pend_m = 0; ovr_m = 0; ever_m = 0;
    for (int r = 0; r < 10; r++) begin
      reload_m = 16'($urandom_range(0, 4));
      bus_write(ADDR_RELOAD_LO, reload_m[7:0]);
      bus_write(ADDR_RELOAD_HI, reload_m[15:8]);
      cnt_m = reload_m;
      vec = 8'($urandom);
      bus_write(ADDR_VECTOR, vec);
      expect_read("rand_vector_rb", ADDR_VECTOR, vec & 8'hFE);
      if (r == 0) bus_write(ADDR_CTRL, 8'h01);
      n = $urandom_range(4, 24);
      repeat (n) begin
        t = 1'($urandom_range(0, 1));
        @(negedge gclk1); tick = t;
        if (t) begin
          if (cnt_m == 0) begin
            cnt_m = reload_m;
            if (pend_m) ovr_m = 1;
            pend_m = 1;
            ever_m = 1;
          end else begin
            cnt_m--;
          end
        end
      end
      @(negedge gclk1); tick = 1'b0;
      cyc(2);
      expect_read("rand_ctrl", ADDR_CTRL, ctrl_model(1, pend_m, 0, ovr_m));
      check("rand_intn", {15'h0, intn}, {15'h0, !ever_m});
      if ($urandom_range(0, 2) == 0) begin
        bus_write(ADDR_CTRL, 8'h03);
        pend_m = 0; ovr_m = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interruptus_irq.md
INTERRUPTUS_IRQ -- requirements
Module: interruptus_irq

Interface
REQ-001 SHALL have port gclk1, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port A, input, 20, CPU address; only A[7:0] decoded.
REQ-004 SHALL have port d, inout, 8, CPU data bus; high-Z unless driving a read or vector.
REQ-005 SHALL have ports iorqn, m1n, rdn, wrn, input, 1 each, active-low Z80 bus strobes.
REQ-006 SHALL have port tick, input, 1, one-gclk1 count-enable pulse from the upstream timer.
REQ-007 SHALL have port intn, output, 1, active-low interrupt request to the CPU.
REQ-008 SHALL have port irq_active, output, 1, high in states PEND, ACK and INSVC (LED drive).

Function
REQ-009 SHALL define IO cycle = iorqn low and m1n high; ACK cycle = iorqn low and m1n low.
REQ-010 SHALL register map: 0x1D RELOAD_LO (R/W), 0x1E RELOAD_HI (R/W), 0x1F CTRL (R/W), 0x20 VECTOR (R/W, bit0 reads and drives 0).
REQ-011 SHALL CTRL write: bit0 ENABLE; bit1 W1C clears PENDING and OVERRUN; bit2 EOI, self-clearing.
REQ-012 SHALL CTRL read: bit0 ENABLE, bit1 PENDING, bit2 INSVC, bit3 OVERRUN, bits7:4 zero.
REQ-013 SHALL pass iorqn, m1n, rdn, wrn through a 2-flop synchronizer; a write commits once, in the cycle the synchronized wrn falls during an IO cycle.
REQ-014 SHALL drive d combinationally from the raw strobes during an IO read of a mapped address; unmapped addresses leave d high-Z.
REQ-015 SHALL hold a 16-bit down-counter CNT that decrements only when tick=1 and ENABLE=1.
REQ-016 SHALL, on tick with CNT=0, load CNT from {RELOAD_HI,RELOAD_LO} and set PENDING; RELOAD=0 gives an event every tick.
REQ-017 SHALL set OVERRUN when an event occurs while PENDING is already set; PENDING never counts above one.
REQ-018 SHALL, on a RELOAD_HI write, load CNT from the new reload value in the same cycle.
REQ-019 SHALL implement the FSM IDLE, PEND, ACK, INSVC; intn=0 only in PEND and ACK.
REQ-020 SHALL go IDLE->PEND when PENDING=1 and ENABLE=1.
REQ-021 SHALL go PEND->ACK on the synchronized ACK cycle and clear PENDING.
REQ-022 SHALL drive VECTOR onto d while raw iorqn=0 and m1n=0, in PEND or ACK.
REQ-023 SHALL go ACK->INSVC when the synchronized ACK cycle ends.
REQ-024 SHALL go INSVC->IDLE on EOI, or on RETI when REQ-029 applies.
REQ-025 SHALL, when ENABLE clears in PEND, return to IDLE with PENDING kept; INSVC is unaffected.
REQ-026 SHALL give W1C precedence when an event and W1C fall in the same cycle; PENDING ends cleared.

Reset
REQ-027 SHALL on resetn low immediately: FSM=IDLE, intn=1, irq_active=0, d high-Z, all registers and CNT 0, synchronizers reset to inactive (1).
REQ-028 SHALL abort any in-progress ACK or INSVC on reset without driving d.

Configuration
REQ-029 SHALL, with IRQ_RETI_DETECT_EN defined, sample d at each synchronized m1n rising edge with iorqn high, and treat consecutive fetches 0xED then 0x4D as RETI, equivalent to EOI.
REQ-030 SHALL, without IRQ_RETI_DETECT_EN, leave INSVC only by EOI and contain no fetch-tracking logic.

Structure
REQ-031 SHALL place register addresses, CTRL bit positions and FSM state encoding in package interruptus_pkg.
REQ-032 SHALL instantiate sub-module irq_bus_sync (2-flop synchronizer plus edge detect) once per strobe.

Verification
REQ-033 SHALL test: RELOAD=0x0003, ENABLE=1, 4 ticks -> intn low after 4th tick plus FSM latency; CTRL reads 0x03.
REQ-034 SHALL test: VECTOR=0x41, ACK cycle -> d=0x40 during ACK; CTRL reads 0x05 after; intn stays high.
REQ-035 SHALL test: 2 further events in INSVC -> PENDING=1, OVERRUN=1; EOI -> IDLE->PEND, intn low again.
REQ-036 SHALL test: ENABLE=0 while intn low -> intn high, PENDING=1; ENABLE=1 -> intn low.
REQ-037 SHALL test: resetn low during ACK -> intn=1, d=Z, CTRL reads 0x00.
REQ-038 SHALL test: with IRQ_RETI_DETECT_EN, M1 fetches 0xED then 0x4D in INSVC -> IDLE; 0xED,0x00,0x4D -> stays INSVC.
